// File: rtl/wta_pkg.sv
// Shared definitions for the WTA readout bus: arbiter state encoding,
// legal select range and the named register select codes.
package wta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } wta_state_t;

    localparam int unsigned WTA_SEL_MIN = 1;
    localparam int unsigned WTA_SEL_MAX = 15;

    localparam int unsigned SEL_N      = 1;
    localparam int unsigned SEL_M      = 2;
    localparam int unsigned SEL_P      = 3;
    localparam int unsigned SEL_R1     = 4;
    localparam int unsigned SEL_ROW    = 5;
    localparam int unsigned SEL_COL    = 6;
    localparam int unsigned SEL_CURR   = 7;
    localparam int unsigned SEL_SUM    = 8;
    localparam int unsigned SEL_STA    = 9;
    localparam int unsigned SEL_STB    = 10;
    localparam int unsigned SEL_STC    = 11;
    localparam int unsigned SEL_A      = 12;
    localparam int unsigned SEL_B      = 13;
    localparam int unsigned SEL_R      = 14;
    localparam int unsigned SEL_COREID = 15;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping upward modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   win
);

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // explicit modulo keeps the wrap correct for non-power-of-two NUM_REQ
            if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((32'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/wta_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared WTA readout bus: one
// select per transfer, IDLE -> DRIVE -> RESP, registered response.
module wta_bus_arbiter
    import wta_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 8,
    parameter int DATA_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [SEL_W-1:0]         wta_sel,
    output logic                     wta_en,
    input  logic [DATA_W-1:0]        wta_data,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic                     rerr
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    wta_state_t         state, state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic [SEL_W-1:0]   sel_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rerr_q;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_win;
    logic [SEL_W-1:0]   pick_sel;
    logic               sel_in_range;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .win   (pick_win)
    );

    always_comb begin
        pick_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_win == PTR_W'(i)) begin
                pick_sel = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    assign sel_in_range = (32'(sel_q) >= WTA_SEL_MIN) && (32'(sel_q) <= WTA_SEL_MAX);

    always_comb begin
        state_next = state;
        gnt        = '0;
        rvalid     = '0;
        wta_sel    = '0;
        wta_en     = 1'b0;
        rerr       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                gnt        = NUM_REQ'(1) << win;
                wta_sel    = sel_q;
                wta_en     = sel_in_range;
                state_next = RESP;
            end
            RESP: begin
                rvalid     = NUM_REQ'(1) << win;
                rerr       = rerr_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        win   <= pick_win;
                        sel_q <= pick_sel;
                    end
                end
                DRIVE: begin
                    rdata_q <= sel_in_range ? wta_data : '0;
                    rerr_q  <= !sel_in_range;
                end
                RESP: begin
                    ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: doc/wta_bus_arbiter.md
# wta_bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit write-to-accumulator (WTA) readout bus of the CCSS processor. Up to NUM_REQ requesters (cores, debug port) each ask for one register value by select code 1..15. The arbiter grants one requester at a time and drives `wta_sel`/`wta_en` into the WTA mux for exactly one cycle. It then registers the returned word and hands it back with a one-hot valid. It sits between the core-side request ports and the combinational WTA mux.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- SEL_W, 8, width of register select code
- DATA_W, 16, width of WTA data bus
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_sel  in  NUM_REQ*SEL_W  packed select codes; requester i at bits [i*SEL_W +: SEL_W]
- gnt  out  NUM_REQ  one-hot grant, high during DRIVE
- busy  out  1  high in any state other than IDLE
- wta_sel  out  SEL_W  select to WTA mux
- wta_en  out  1  enable to WTA mux
- wta_data  in  DATA_W  combinational mux output
- rdata  out  DATA_W  captured word, valid with rvalid
- rvalid  out  NUM_REQ  one-hot, one-cycle response strobe
- rerr  out  1  high with rvalid when the select was out of range

## Operation
- States: IDLE, DRIVE, RESP.
- IDLE, no req: stay in IDLE; all strobes low.
- IDLE, any req high: a round-robin search starts at `ptr` and wraps upward; the first requester with req high wins.
  - Latch the winner index `win` and `sel_q` = req_sel[win].
  - Next state is DRIVE.
- DRIVE, one cycle:
  - gnt[win]=1.
  - wta_sel=sel_q.
  - wta_en=1 only if 1 ≤ sel_q ≤ 15; otherwise wta_en=0.
  - At the ending edge: rdata ← wta_data if in range, else 0; rerr_q ← out-of-range flag.
  - Next state is RESP.
- RESP, one cycle:
  - rvalid[win]=1; rerr=rerr_q.
  - ptr ← (win+1) mod NUM_REQ.
  - Next state is IDLE.
- Requests are latched. Dropping req after the IDLE decision does not cancel the transfer; the response is still delivered.
- A requester holds req and req_sel stable until it sees its rvalid. Holding req through RESP does not cause a double serve, because IDLE re-arbitrates and ptr has already advanced past it.
- wta_sel is 0 whenever the state is not DRIVE. The mux therefore sees no select outside a transfer.
- rdata holds its last value between transfers. It is only meaningful with rvalid.
- ptr is log2(NUM_REQ) bits wide (minimum 1 bit). Wrap uses explicit modulo for non-power-of-two NUM_REQ.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, busy=0, wta_sel=0, wta_en=0, rdata=0, rvalid=0, rerr=0.
- Reset mid-transfer:
  - The transfer is abandoned and no rvalid is issued.
  - The requester must re-request.
  - rst wins over every other event in the same cycle.
- Latency:
  - req high in IDLE at cycle 0 → gnt/wta_en in cycle 1 → rvalid/rdata in cycle 2.
  - Next arbitration happens in cycle 3.
- Throughput: one transfer per 3 cycles under saturation.
- Fairness: under continuous all-request load, every requester is served once per NUM_REQ transfers.
- wta_data is sampled only at the edge ending DRIVE. The mux path must meet single-cycle timing.
- gnt and rvalid are never high in the same cycle. At most one bit of each is high.

## Structure
- Shared package `wta_pkg`:
  - state enum {IDLE, DRIVE, RESP};
  - WTA_SEL_MIN=1, WTA_SEL_MAX=15;
  - named select constants: SEL_N=1, SEL_M=2, SEL_P=3, SEL_R1=4, SEL_ROW=5, SEL_COL=6, SEL_CURR=7, SEL_SUM=8, SEL_STA=9, SEL_STB=10, SEL_STC=11, SEL_A=12, SEL_B=13, SEL_R=14, SEL_COREID=15.
- Sub-module `rr_picker`:
  - combinational;
  - inputs req and ptr; outputs found and the winner index.
  - Reused by other shared-bus arbiters.
- The top level holds the FSM, the latched win/sel_q, the capture register and ptr.

## Test plan
- Single request:
  - stimulus: req=0001, req_sel[0]=8 (SUM), wta_data=16'h1234;
  - required: cycle 1 gnt=0001, wta_sel=8, wta_en=1; cycle 2 rvalid=0001, rdata=16'h1234, rerr=0; ptr=1.
- Saturation fairness:
  - stimulus: req=1111 held for 12 transfers starting at ptr=0;
  - required: grant order 0,1,2,3,0,1,2,3,0,1,2,3; each rvalid arrives 2 cycles after its IDLE decision.
- Wrap-around:
  - stimulus: ptr=3, req=1001;
  - required: requester 3 is served first, then 0; ptr returns to 1.
- Out-of-range select:
  - stimulus: req_sel[2]=0, then 16;
  - required: wta_en stays 0 in DRIVE; rvalid=0100, rerr=1, rdata=0 in both cases.
- Request dropped after decision:
  - stimulus: req[1] pulses high for 1 cycle in IDLE, req_sel[1]=15, wta_data=16'h0002;
  - required: rvalid=0010 and rdata=16'h0002 are still delivered.
- Reset mid-operation:
  - stimulus: rst asserted during DRIVE;
  - required: next cycle all outputs 0, no rvalid, ptr=0; a new req=0100 is served normally afterwards.
